// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell and a carry flop produce sum = a + b + cin, LSB first.
// Optional macro SERIAL_ADDER_OVF_EN adds a registered signed-overflow output ovf.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, ps, ps_nxt;
  logic             c, c_nxt, bit_s, last;
  logic [CNT_W-1:0] cnt;

  function automatic logic maj3(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

  always_comb begin
    state_nxt = state;
    bit_s     = a_sh[0] ^ b_sh[0] ^ c;
    c_nxt     = maj3(a_sh[0], b_sh[0], c);
    last      = (cnt == CNT_W'(WIDTH - 1));
    ps_nxt    = {bit_s, {(WIDTH-1){1'b0}}} | (ps >> 1);
    unique case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Operand shifters, carry and counter advance only in RUN; results load on the last bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_sh <= '0;
      b_sh <= '0;
      ps   <= '0;
      c    <= 1'b0;
      cnt  <= '0;
      sum  <= '0;
      cout <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh <= a;
            b_sh <= b;
            c    <= cin;
            cnt  <= '0;
          end
        end
        RUN: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          ps   <= ps_nxt;
          c    <= c_nxt;
          cnt  <= cnt + 1'b1;
          if (last) begin
            sum  <= ps_nxt;
            cout <= c_nxt;
`ifdef SERIAL_ADDER_OVF_EN
            // c here is the carry into the MSB, c_nxt the carry out of it.
            ovf  <= c ^ c_nxt;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_serial_adder.sv
// Directed testbench for serial_adder (WIDTH=8), hand-computed expected results.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       reset, start, cin;
  logic [7:0] a, b;
  logic       busy, done, cout;
  logic [7:0] sum;
`ifdef SERIAL_ADDER_OVF_EN
  logic       ovf;
`endif

  int checks = 0;
  int errors = 0;

  serial_adder #(.WIDTH(8)) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf  (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] av, input logic [7:0] bv, input logic cv);
    a = av; b = bv; cin = cv; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Returns the number of cycles until done, or -1 after the cycle budget.
  task automatic wait_done(output int n, output int busy_cycles);
    n = 0;
    busy_cycles = 0;
    while (!done && n < 30) begin
      if (busy) busy_cycles++;
      tick();
      n++;
    end
    if (!done) n = -1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    tick(); tick();
    reset = 1'b0;
    checks++;
    if ({busy, done, cout, sum} !== 11'd0) begin
      errors++;
      $display("FAIL reset_outputs got busy=%b done=%b cout=%b sum=%h exp all zero", busy, done, cout, sum);
    end
`ifdef SERIAL_ADDER_OVF_EN
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_ovf got %b exp 0", ovf);
    end
`endif
  endtask

  task automatic test_basic();
    int n, bc;
    do_start(8'h5A, 8'h3C, 1'b0);
    wait_done(n, bc);
    checks++;
    if (n !== 8) begin
      errors++;
      $display("FAIL basic_latency got %0d exp 8", n);
    end
    checks++;
    if (bc !== 8) begin
      errors++;
      $display("FAIL basic_busy_cycles got %0d exp 8", bc);
    end
    checks++;
    if ({cout, sum} !== {1'b0, 8'h96} || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_result got cout=%b sum=%h busy=%b exp cout=0 sum=96 busy=0", cout, sum, busy);
    end
`ifdef SERIAL_ADDER_OVF_EN
    checks++;
    if (ovf !== 1'b1) begin
      errors++;
      $display("FAIL basic_ovf got %b exp 1", ovf);
    end
`endif
    tick();
    checks++;
    if (done !== 1'b0 || sum !== 8'h96) begin
      errors++;
      $display("FAIL basic_pulse_len got done=%b sum=%h exp done=0 sum=96", done, sum);
    end
  endtask

  task automatic test_carry();
    int n, bc;
    do_start(8'hFF, 8'h01, 1'b0);
    wait_done(n, bc);
    checks++;
    if (n !== 8 || {cout, sum} !== {1'b1, 8'h00}) begin
      errors++;
      $display("FAIL carry_wrap got n=%0d cout=%b sum=%h exp n=8 cout=1 sum=00", n, cout, sum);
    end
`ifdef SERIAL_ADDER_OVF_EN
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("FAIL carry_wrap_ovf got %b exp 0", ovf);
    end
`endif
    tick();
    do_start(8'h00, 8'h00, 1'b1);
    wait_done(n, bc);
    checks++;
    if (n !== 8 || {cout, sum} !== {1'b0, 8'h01}) begin
      errors++;
      $display("FAIL carry_in_only got n=%0d cout=%b sum=%h exp n=8 cout=0 sum=01", n, cout, sum);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    int last_t = -1;
    a = 8'h7F; b = 8'h01; cin = 1'b0; start = 1'b1;
    for (int i = 0; i < 45; i++) begin
      tick();
      if (done) begin
        pulses++;
        checks++;
        if ({cout, sum} !== {1'b0, 8'h80}) begin
          errors++;
          $display("FAIL b2b_result got cout=%b sum=%h exp cout=0 sum=80", cout, sum);
        end
`ifdef SERIAL_ADDER_OVF_EN
        checks++;
        if (ovf !== 1'b1) begin
          errors++;
          $display("FAIL b2b_ovf got %b exp 1", ovf);
        end
`endif
        if (last_t >= 0) begin
          checks++;
          if (i - last_t !== 10) begin
            errors++;
            $display("FAIL b2b_period got %0d exp 10", i - last_t);
          end
        end
        last_t = i;
      end
      // Scramble operands except when the next edge can accept a start.
      if (!busy && !done) begin
        a = 8'h7F; b = 8'h01;
      end else begin
        a = 8'hA5 ^ 8'(i); b = 8'h3C + 8'(i);
      end
    end
    checks++;
    if (pulses !== 4) begin
      errors++;
      $display("FAIL b2b_pulse_count got %0d exp 4", pulses);
    end
    start = 1'b0;
    for (int i = 0; i < 12 && (busy || done); i++) tick();
  endtask

  task automatic test_reset_abort();
    int n, bc;
    int seen_done = 0;
    do_start(8'h12, 8'h34, 1'b0);
    tick(); tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || {cout, sum} !== 9'd0) begin
      errors++;
      $display("FAIL abort_clear got busy=%b cout=%b sum=%h exp busy=0 cout=0 sum=00", busy, cout, sum);
    end
    for (int i = 0; i < 12; i++) begin
      if (done || busy) seen_done++;
      tick();
    end
    checks++;
    if (seen_done !== 0) begin
      errors++;
      $display("FAIL abort_no_done got %0d active cycles exp 0", seen_done);
    end
    do_start(8'h01, 8'h02, 1'b0);
    wait_done(n, bc);
    checks++;
    if (n !== 8 || {cout, sum} !== {1'b0, 8'h03}) begin
      errors++;
      $display("FAIL abort_restart got n=%0d cout=%b sum=%h exp n=8 cout=0 sum=03", n, cout, sum);
    end
    tick();
  endtask

  task automatic test_hold();
    int n, bc;
    int bad = 0;
    do_start(8'h5A, 8'h3C, 1'b0);
    wait_done(n, bc);
    tick();
    do_start(8'hFF, 8'hFF, 1'b1);
    for (int i = 0; i < 30 && !done; i++) begin
      if (sum !== 8'h96 || cout !== 1'b0) bad++;
      tick();
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL hold_during_run got %0d changed cycles exp 0", bad);
    end
    checks++;
    if (done !== 1'b1 || {cout, sum} !== {1'b1, 8'hFF}) begin
      errors++;
      $display("FAIL hold_final got done=%b cout=%b sum=%h exp done=1 cout=1 sum=ff", done, cout, sum);
    end
`ifdef SERIAL_ADDER_OVF_EN
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("FAIL hold_ovf got %b exp 0", ovf);
    end
`endif
    tick();
  endtask

  task automatic test_reset_start();
    int rose = 0;
    a = 8'h11; b = 8'h22; cin = 1'b0;
    reset = 1'b1; start = 1'b1;
    tick();
    reset = 1'b0; start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (busy || done) rose++;
      tick();
    end
    checks++;
    if (rose !== 0 || sum !== 8'h00) begin
      errors++;
      $display("FAIL reset_start got active=%0d sum=%h exp active=0 sum=00", rose, sum);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_back_to_back();
    test_reset_abort();
    test_hold();
    test_reset_start();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
